// File: rtl/dcache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller_pkg
// Description : Shared constants, FSM state encoding and word-select helper
//               for the direct-mapped data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_controller_pkg;

    localparam int c_WORD_W     = 32;
    localparam int c_LINE_W     = 256;
    localparam int c_OFFSET_W   = 5;
    localparam int c_WORD_SEL_W = 3;
    localparam int c_STATE_W    = 2;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE      = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_WRITEBACK = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_ALLOCATE  = 2'd2;

    function automatic logic [c_WORD_W-1:0] selectWord(
        input logic [c_LINE_W-1:0]     line,
        input logic [c_WORD_SEL_W-1:0] sel
    );
        return line[int'(sel)*c_WORD_W +: c_WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_controller_sram.sv
`default_nettype none
// ============================================================================
// Module      : dcache_sram
// Description : Valid/dirty/tag/data arrays with combinational read, a
//               word-write port for store hits and a full-line refill port.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_sram
    import dcache_controller_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 32 - c_OFFSET_W - INDEX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INDEX_W-1:0]      i_rdIndex,
    output logic                    o_rdValid,
    output logic                    o_rdDirty,
    output logic [TAG_W-1:0]        o_rdTag,
    output logic [c_LINE_W-1:0]     o_rdLine,
    input  logic                    i_wordWe,
    input  logic [INDEX_W-1:0]      i_wordIndex,
    input  logic [c_WORD_SEL_W-1:0] i_wordSel,
    input  logic [c_WORD_W-1:0]     i_wordData,
    input  logic                    i_lineWe,
    input  logic [INDEX_W-1:0]      i_lineIndex,
    input  logic [TAG_W-1:0]        i_lineTag,
    input  logic [c_LINE_W-1:0]     i_lineData
);

    localparam int c_SETS = 1 << INDEX_W;

    logic [c_SETS-1:0]   r_valid;
    logic [c_SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]    r_tag  [c_SETS];
    logic [c_LINE_W-1:0] r_data [c_SETS];

    assign o_rdValid = r_valid[i_rdIndex];
    assign o_rdDirty = r_dirty[i_rdIndex];
    assign o_rdTag   = r_tag[i_rdIndex];
    assign o_rdLine  = r_data[i_rdIndex];

    // Status bits are the only state cleared by reset; tags/data stay as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_lineWe) begin
                r_valid[i_lineIndex] <= 1'b1;
                r_dirty[i_lineIndex] <= 1'b0;
            end
            if (i_wordWe) begin
                r_dirty[i_wordIndex] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_lineWe) begin
            r_tag[i_lineIndex]  <= i_lineTag;
            r_data[i_lineIndex] <= i_lineData;
        end
        if (i_wordWe) begin
            r_data[i_wordIndex][int'(i_wordSel)*c_WORD_W +: c_WORD_W] <= i_wordData;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-back, write-allocate data cache with
//               32-byte lines and a single outstanding line transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int INDEX_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic [31:0]         cpu_data_i,
    output logic [31:0]         cpu_data_o,
    output logic                cpu_stall_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    output logic [31:0]         mem_addr_o,
    output logic [c_LINE_W-1:0] mem_data_o,
    input  logic [c_LINE_W-1:0] mem_data_i,
    input  logic                mem_ack_i
);

    localparam int c_TAG_W       = 32 - c_OFFSET_W - INDEX_W;
    localparam int c_LINE_ADDR_W = 32 - c_OFFSET_W;

    logic [c_STATE_W-1:0]     r_state;
    logic [c_LINE_ADDR_W-1:0] r_missLine;
    logic [c_LINE_ADDR_W-1:0] r_memLine;
    logic                     r_memEnable;
    logic                     r_memWrite;

    logic [INDEX_W-1:0]       w_reqIndex;
    logic [c_TAG_W-1:0]       w_reqTag;
    logic [c_WORD_SEL_W-1:0]  w_wordSel;
    logic [INDEX_W-1:0]       w_missIndex;
    logic [c_TAG_W-1:0]       w_missTag;
    logic [INDEX_W-1:0]       w_rdIndex;
    logic                     w_rdValid;
    logic                     w_rdDirty;
    logic [c_TAG_W-1:0]       w_rdTag;
    logic [c_LINE_W-1:0]      w_rdLine;
    logic                     w_isIdle;
    logic                     w_hit;
    logic                     w_idleHit;
    logic                     w_idleMiss;
    logic                     w_wordWe;
    logic                     w_lineWe;
    logic [1:0]               w_unusedByteOffset;

    assign w_reqIndex         = cpu_addr_i[c_OFFSET_W +: INDEX_W];
    assign w_reqTag           = cpu_addr_i[31 -: c_TAG_W];
    assign w_wordSel          = cpu_addr_i[2 +: c_WORD_SEL_W];
    assign w_unusedByteOffset = cpu_addr_i[1:0];

    assign w_missIndex = r_missLine[INDEX_W-1:0];
    assign w_missTag   = r_missLine[c_LINE_ADDR_W-1 -: c_TAG_W];

    // While a line transfer is in flight the arrays are addressed by the
    // latched miss, so the victim stays visible even if the request drops.
    assign w_isIdle  = (r_state == c_ST_IDLE);
    assign w_rdIndex = w_isIdle ? w_reqIndex : w_missIndex;

    assign w_hit      = cpu_req_i && w_rdValid && (w_rdTag == w_reqTag);
    assign w_idleHit  = w_isIdle && w_hit;
    assign w_idleMiss = w_isIdle && cpu_req_i && !w_hit;

    assign w_wordWe = w_idleHit && cpu_we_i;
    assign w_lineWe = (r_state == c_ST_ALLOCATE) && mem_ack_i;

    assign cpu_data_o   = selectWord(w_rdLine, w_wordSel);
    assign cpu_stall_o  = !w_isIdle || w_idleMiss;
    assign mem_enable_o = r_memEnable;
    assign mem_write_o  = r_memWrite;
    assign mem_addr_o   = {r_memLine, {c_OFFSET_W{1'b0}}};
    assign mem_data_o   = w_rdLine;

    dcache_sram #(
        .INDEX_W (INDEX_W),
        .TAG_W   (c_TAG_W)
    ) u_sram (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_rdIndex   (w_rdIndex),
        .o_rdValid   (w_rdValid),
        .o_rdDirty   (w_rdDirty),
        .o_rdTag     (w_rdTag),
        .o_rdLine    (w_rdLine),
        .i_wordWe    (w_wordWe),
        .i_wordIndex (w_reqIndex),
        .i_wordSel   (w_wordSel),
        .i_wordData  (cpu_data_i),
        .i_lineWe    (w_lineWe),
        .i_lineIndex (w_missIndex),
        .i_lineTag   (w_missTag),
        .i_lineData  (mem_data_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_missLine  <= '0;
            r_memLine   <= '0;
            r_memEnable <= 1'b0;
            r_memWrite  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_idleMiss) begin
                        r_missLine  <= {w_reqTag, w_reqIndex};
                        r_memEnable <= 1'b1;
                        if (w_rdValid && w_rdDirty) begin
                            r_state    <= c_ST_WRITEBACK;
                            r_memWrite <= 1'b1;
                            r_memLine  <= {w_rdTag, w_reqIndex};
                        end else begin
                            r_state    <= c_ST_ALLOCATE;
                            r_memWrite <= 1'b0;
                            r_memLine  <= {w_reqTag, w_reqIndex};
                        end
                    end
                end
                c_ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state    <= c_ST_ALLOCATE;
                        r_memWrite <= 1'b0;
                        r_memLine  <= r_missLine;
                    end
                end
                c_ST_ALLOCATE: begin
                    if (mem_ack_i) begin
                        r_state     <= c_ST_IDLE;
                        r_memEnable <= 1'b0;
                        r_memWrite  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_memEnable <= 1'b0;
                    r_memWrite  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Directed plus randomized bench for dcache_controller against
//               a set-array/memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpuReq;
    logic         cpuWe;
    logic [31:0]  cpuAddr;
    logic [31:0]  cpuWdata;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] memRdata;
    logic         memAck;

    int checks = 0;
    int errors = 0;

    // Reference model: per-set status/tag/line plus a sparse backing memory.
    logic         mValid [16];
    logic         mDirty [16];
    logic [22:0]  mTag   [16];
    logic [255:0] mLine  [16];
    logic [255:0] memModel [logic [26:0]];

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_req_i    (cpuReq),
        .cpu_we_i     (cpuWe),
        .cpu_addr_i   (cpuAddr),
        .cpu_data_i   (cpuWdata),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (memRdata),
        .mem_ack_i    (memAck)
    );

    function automatic logic [255:0] patternLine(input logic [26:0] ln);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = {5'(k), ln};
        return r;
    endfunction

    function automatic logic [255:0] memRead(input logic [26:0] ln);
        if (memModel.exists(ln)) return memModel[ln];
        return patternLine(ln);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
        end
    endtask

    // Entered and left on a falling edge; leaves the bench one edge later.
    task automatic applyReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        #1;
        chk("reset_stall", 256'(cpu_stall_o), 256'(0));
        chk("reset_mem_enable", 256'(mem_enable_o), 256'(0));
        chk("reset_mem_write", 256'(mem_write_o), 256'(0));
        @(negedge clk);
    endtask

    // Services one line transfer with a random number of wait cycles.
    task automatic memPhase(input logic isWrite, input logic [26:0] expLine, input logic [255:0] expData);
        int lat;
        lat = $urandom_range(0, 3);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            memAck = 1'b0;
            #1;
            chk("mem_enable_busy", 256'(mem_enable_o), 256'(1));
            chk("mem_write_busy", 256'(mem_write_o), 256'(isWrite));
            chk("mem_addr", 256'(mem_addr_o), 256'({expLine, 5'b0}));
            if (isWrite) chk("mem_data_wb", mem_data_o, expData);
            chk("stall_busy", 256'(cpu_stall_o), 256'(1));
            if (c == lat) begin
                memAck   = 1'b1;
                memRdata = isWrite ? {8{$urandom()}} : memRead(expLine);
            end
        end
    endtask

    task automatic doAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic missed, output logic sawWb, output logic [31:0] rdata);
        logic [3:0]  idx;
        logic [22:0] tag;
        logic [2:0]  word;
        logic        hit;
        idx  = addr[8:5];
        tag  = addr[31:9];
        word = addr[4:2];
        cpuReq   = 1'b1;
        cpuWe    = we;
        cpuAddr  = addr;
        cpuWdata = wdata;
        #1;
        hit    = mValid[idx] && (mTag[idx] == tag);
        missed = !hit;
        sawWb  = 1'b0;
        rdata  = '0;
        chk("stall_on_request", 256'(cpu_stall_o), 256'(!hit));
        if (!hit) begin
            if (mValid[idx] && mDirty[idx]) begin
                sawWb = 1'b1;
                memPhase(1'b1, {mTag[idx], idx}, mLine[idx]);
                memModel[{mTag[idx], idx}] = mLine[idx];
            end
            memPhase(1'b0, {tag, idx}, '0);
            @(negedge clk);
            memAck = 1'b0;
            #1;
            mLine[idx]  = memRead({tag, idx});
            mValid[idx] = 1'b1;
            mDirty[idx] = 1'b0;
            mTag[idx]   = tag;
            chk("stall_after_refill", 256'(cpu_stall_o), 256'(0));
        end
        chk("mem_enable_idle", 256'(mem_enable_o), 256'(0));
        chk("mem_write_idle", 256'(mem_write_o), 256'(0));
        if (!we) begin
            rdata = cpu_data_o;
            chk("load_data", 256'(cpu_data_o), 256'(mLine[idx][int'(word)*32 +: 32]));
        end
        @(posedge clk);
        if (we) begin
            mLine[idx][int'(word)*32 +: 32] = wdata;
            mDirty[idx] = 1'b1;
        end
        @(negedge clk);
        cpuReq = 1'b0;
    endtask

    initial begin
        logic         missed;
        logic         sawWb;
        logic [31:0]  rdata;
        logic [255:0] seedLine;
        logic [22:0]  tagPool [4];

        rst      = 1'b1;
        cpuReq   = 1'b0;
        cpuWe    = 1'b0;
        cpuAddr  = '0;
        cpuWdata = '0;
        memRdata = '0;
        memAck   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mTag[i]  = '0;
            mLine[i] = '0;
        end
        seedLine = patternLine(27'd8);
        seedLine[63:32] = 32'hDEADBEEF;
        memModel[27'd8] = seedLine;

        @(negedge clk);
        applyReset();

        // Cold load, store hit, read-back
        doAccess(1'b0, 32'h0000_0104, 32'h0, missed, sawWb, rdata);
        chk("cold_load_missed", 256'(missed), 256'(1));
        chk("cold_load_no_wb", 256'(sawWb), 256'(0));
        chk("cold_load_data", 256'(rdata), 256'(32'hDEADBEEF));
        doAccess(1'b1, 32'h0000_0108, 32'h1234_5678, missed, sawWb, rdata);
        chk("store_hit_no_miss", 256'(missed), 256'(0));
        doAccess(1'b0, 32'h0000_0108, 32'h0, missed, sawWb, rdata);
        chk("store_readback", 256'(rdata), 256'(32'h1234_5678));

        // Dirty eviction of set 8
        doAccess(1'b0, 32'h0000_0300, 32'h0, missed, sawWb, rdata);
        chk("evict_missed", 256'(missed), 256'(1));
        chk("evict_writeback", 256'(sawWb), 256'(1));

        // Store miss with clean victim, then prove set 2 became dirty
        doAccess(1'b1, 32'h0000_0044, 32'hA5A5_A5A5, missed, sawWb, rdata);
        chk("store_miss_no_wb", 256'(sawWb), 256'(0));
        doAccess(1'b0, 32'h0000_0044, 32'h0, missed, sawWb, rdata);
        chk("store_miss_readback", 256'(rdata), 256'(32'hA5A5_A5A5));
        doAccess(1'b0, 32'h0000_0244, 32'h0, missed, sawWb, rdata);
        chk("set2_dirty_evict", 256'(sawWb), 256'(1));

        // Reset while a refill is outstanding, then a late ack
        applyReset();
        cpuReq  = 1'b1;
        cpuWe   = 1'b0;
        cpuAddr = 32'h0000_0104;
        #1;
        chk("midalloc_stall", 256'(cpu_stall_o), 256'(1));
        @(negedge clk);
        #1;
        chk("midalloc_enable", 256'(mem_enable_o), 256'(1));
        chk("midalloc_addr", 256'(mem_addr_o), 256'(32'h0000_0100));
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        cpuReq = 1'b0;
        modelReset();
        #1;
        chk("midalloc_rst_enable", 256'(mem_enable_o), 256'(0));
        chk("midalloc_rst_stall", 256'(cpu_stall_o), 256'(0));
        memAck   = 1'b1;
        memRdata = {8{$urandom()}};
        @(negedge clk);
        memAck = 1'b0;
        #1;
        chk("late_ack_enable", 256'(mem_enable_o), 256'(0));
        chk("late_ack_stall", 256'(cpu_stall_o), 256'(0));
        @(negedge clk);
        doAccess(1'b0, 32'h0000_0104, 32'h0, missed, sawWb, rdata);
        chk("after_rst_missed", 256'(missed), 256'(1));
        chk("after_rst_data", 256'(rdata), 256'(32'hDEADBEEF));

        // Spurious ack in IDLE leaves everything untouched
        memAck   = 1'b1;
        memRdata = {8{$urandom()}};
        #1;
        chk("spurious_enable", 256'(mem_enable_o), 256'(0));
        chk("spurious_stall", 256'(cpu_stall_o), 256'(0));
        @(negedge clk);
        memAck = 1'b0;
        @(negedge clk);
        doAccess(1'b0, 32'h0000_0104, 32'h0, missed, sawWb, rdata);
        chk("spurious_still_hit", 256'(missed), 256'(0));
        chk("spurious_data", 256'(rdata), 256'(32'hDEADBEEF));

        // Randomized traffic over a few conflicting tags
        tagPool[0] = 23'h000000;
        tagPool[1] = 23'h000001;
        tagPool[2] = 23'h000002;
        tagPool[3] = 23'h7FFFFF;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                applyReset();
            end else begin
                logic [31:0] a;
                a = {tagPool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                doAccess(1'($urandom_range(0, 1)), a, $urandom(), missed, sawWb, rdata);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, meaning the set-index width (16 sets).
REQ-002 SHALL have one clock and one reset: clk_i is the single clock; reset is synchronous and active-high, port rst_i.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- cpu_req_i  in  1  MEM-stage load/store valid
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  freeze whole pipeline
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  1 = line write, 0 = line read
- mem_addr_o  out  32  line-aligned address
- mem_data_o  out  256  line write data
- mem_data_i  in  256  line read data
- mem_ack_i  in  1  one-cycle completion pulse

Function
REQ-004 SHALL implement a direct-mapped, write-back, write-allocate cache with 32-byte lines.
REQ-005 SHALL split the address as: tag = addr[31:5+INDEX_W]; index = addr[4+INDEX_W:5]; word = addr[4:2]; addr[1:0] ignored.
REQ-006 SHALL store per set: valid bit, dirty bit, tag and a 256-bit line.
REQ-007 SHALL define a hit as cpu_req_i AND valid[index] AND the stored tag equals the request tag.
REQ-008 SHALL use an FSM with states IDLE, WRITEBACK and ALLOCATE.
REQ-009 On a load hit in IDLE, SHALL drive cpu_data_o combinationally with the selected word and keep cpu_stall_o=0, giving zero added latency.
REQ-010 On a store hit in IDLE, SHALL write cpu_data_i into the selected word and set dirty=1 at the clock edge, with cpu_stall_o=0.
REQ-011 On a miss in IDLE, SHALL drive cpu_stall_o=1 combinationally in the same cycle, then:
- if the victim set is valid and dirty, go to WRITEBACK;
- otherwise go to ALLOCATE.
REQ-012 In WRITEBACK, SHALL hold mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0} and mem_data_o=victim line stable until mem_ack_i, then go to ALLOCATE.
REQ-013 In ALLOCATE, SHALL hold mem_enable_o=1, mem_write_o=0 and mem_addr_o={req tag, index, 5'b0} until mem_ack_i. On ack it SHALL:
- write mem_data_i into the line;
- set valid=1, dirty=0 and the tag;
- return to IDLE.
REQ-014 SHALL keep cpu_stall_o=1 in WRITEBACK and ALLOCATE. On the first IDLE cycle after a refill the access hits and is serviced per REQ-009/REQ-010, so a store miss sets dirty there.
REQ-015 SHALL ignore mem_ack_i in IDLE.
REQ-016 SHALL complete a started WRITEBACK/ALLOCATE sequence even if cpu_req_i drops; the pipeline holds the request stable while stalled.
REQ-017 When idle or on a hit, SHALL hold mem_enable_o=0 and mem_write_o=0; cpu_data_o is don't-care when there is no load hit.

Reset
REQ-018 When rst_i=1 at a clock edge, SHALL set state=IDLE and clear all valid and dirty bits. Next-cycle outputs are then mem_enable_o=0, mem_write_o=0, and cpu_stall_o=0 unless a new miss is presented. Tag and data arrays are not cleared.
REQ-019 SHALL abandon an in-flight memory transaction when reset is asserted mid-operation; a late mem_ack_i after reset is ignored.

Structure
REQ-020 SHALL take the state encoding, line width (256), offset width (5) and word-select width (3) from the shared CPU package.
REQ-021 SHALL keep storage in one sub-module, dcache_sram, containing the valid/dirty/tag/data arrays, with:
- combinational read;
- synchronous write;
- a word-enable port for store hits;
- a full-line port for refill.

Verification
REQ-022 Cold load: after reset, load 0x0000_0104 → stall=1; ALLOCATE with mem_addr_o=0x0000_0100; ack with line word1=0xDEADBEEF → next cycle cpu_data_o=0xDEADBEEF, stall=0.
REQ-023 Store hit: store 0x1234_5678 to 0x0000_0108 after REQ-022 → no stall; a following load of 0x108 returns 0x12345678; dirty[8]=1.
REQ-024 Dirty eviction: load 0x0000_0300 (same index 8) → WRITEBACK with mem_addr_o=0x100 and word2=0x12345678, then ALLOCATE with mem_addr_o=0x300, then hit.
REQ-025 Store miss, clean victim: store 0xA5A5A5A5 to 0x0000_0044 → ALLOCATE only (no WRITEBACK); afterwards dirty[2]=1 and a load of 0x44 returns 0xA5A5A5A5.
REQ-026 Reset mid-ALLOCATE: assert rst_i with ack pending → next cycle mem_enable_o=0 and state IDLE; a following load of 0x104 misses again.
REQ-027 Spurious ack: pulse mem_ack_i in IDLE with no request → no change to arrays or outputs.
